// File: rtl/eco_bist_pkg.sv
// Shared types and constants for the ECO BIST controller: FSM states, LFSR taps, MISR polynomials.
package eco_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_SEED = 8'h01;

  // Maximal-length feedback taps for a 2*w-bit left-shifting LFSR (bit i set = l[i] feeds back)
  function automatic logic [15:0] lfsr_taps(input int unsigned w);
    case (w)
      2:       return 16'h000C;
      3:       return 16'h0030;
      4:       return 16'h00B8;
      5:       return 16'h0240;
      6:       return 16'h0829;
      7:       return 16'h2015;
      8:       return 16'hD008;
      default: return 16'h00B8;
    endcase
  endfunction

  // MISR feedback polynomial per signature width
  function automatic logic [31:0] misr_poly(input int unsigned sig_w);
    case (sig_w)
      8:       return 32'h0000_001D;
      16:      return 32'h0000_100B;
      32:      return 32'h04C1_1DB7;
      default: return 32'h0000_100B;
    endcase
  endfunction

endpackage

// File: rtl/eco_bist_misr.sv
// Multiple-input signature register compacting the response word d into sig.
module eco_bist_misr
  import eco_bist_pkg::*;
#(
  parameter int unsigned SIG_W = 16,
  parameter int unsigned W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     d,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(misr_poly(SIG_W));

  logic [SIG_W-1:0] sig_nxt;

  // Shift, fold the MSB back through the polynomial, absorb the response
  always_comb begin
    sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ SIG_W'(d);
    if (sig[SIG_W-1]) begin
      sig_nxt = sig_nxt ^ POLY;
    end
  end

  // Signature register; clear wins over absorb
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/eco_bist_ctrl.sv
// LFSR stimulus, MISR compaction and golden compare for small netlist equivalence runs.
// Optional debug stepping and live counters are enabled by defining ECO_BIST_DIAG_EN.
module eco_bist_ctrl
  import eco_bist_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned NPAT    = 256,
  parameter int unsigned DUT_LAT = 0,
  parameter logic [15:0] SEED    = 16'(DEFAULT_SEED),
  parameter int unsigned SIG_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W-1:0] golden_i,
  input  logic [W-1:0]     y_i,
`ifdef ECO_BIST_DIAG_EN
  input  logic             step_mode,
  input  logic             step,
  output logic [15:0]      diag_cnt,
  output logic [SIG_W-1:0] diag_sig,
`endif
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned LW         = 2 * W;
  localparam int unsigned CW         = 16;
  localparam int unsigned VW         = (DUT_LAT == 0) ? 1 : DUT_LAT;
  localparam logic [LW-1:0] TAPS     = LW'(lfsr_taps(W));
  localparam logic [LW-1:0] SEED_L   = LW'(SEED);
  localparam logic [CW-1:0] LAST_PAT = CW'(NPAT - 1);
  localparam logic [1:0] DRAIN_LAST  = (DUT_LAT == 0) ? 2'd0 : 2'(DUT_LAT - 1);

  state_t           state, state_nxt;
  logic [LW-1:0]    lfsr, lfsr_nxt, ab_q;
  logic [CW-1:0]    cnt;
  logic [1:0]       drain_cnt;
  logic [VW-1:0]    vpipe;
  logic [SIG_W-1:0] misr_sig;
  logic             adv, last_pat, last_drain;
  logic             load, step_pat, issue, misr_en;

`ifdef ECO_BIST_DIAG_EN
  assign adv      = !step_mode || step;
  assign diag_cnt = cnt;
  assign diag_sig = misr_sig;
`else
  assign adv = 1'b1;
`endif

  assign lfsr_nxt   = {lfsr[LW-2:0], ^(lfsr & TAPS)};
  assign last_pat   = (cnt == LAST_PAT);
  assign last_drain = (drain_cnt == DRAIN_LAST);
  assign misr_en    = (DUT_LAT == 0) ? issue : vpipe[VW-1];
  assign a_o        = ab_q[LW-1:W];
  assign b_o        = ab_q[W-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus per-cycle load/advance/issue strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_pat  = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (adv) begin
          issue = 1'b1;
          if (last_pat) begin
            state_nxt = (DUT_LAT == 0) ? DONE : DRAIN;
          end else begin
            step_pat = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (adv && last_drain) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pattern generator, counters, valid pipe and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= '0;
      ab_q      <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      vpipe     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done  <= (state == DONE);
      vpipe <= VW'({vpipe, issue});
      if (load) begin
        lfsr <= SEED_L;
        ab_q <= SEED_L;
        cnt  <= '0;
        pass <= 1'b0;
      end else if (step_pat) begin
        lfsr <= lfsr_nxt;
        ab_q <= lfsr_nxt;
        cnt  <= cnt + CW'(1);
      end
      if ((state != DONE) && (state_nxt == DONE)) begin
        ab_q <= '0;
      end
      if (state != DRAIN) begin
        drain_cnt <= '0;
      end else if (adv) begin
        drain_cnt <= drain_cnt + 2'd1;
      end
      if (state == DONE) begin
        signature <= misr_sig;
        pass      <= (misr_sig == golden_i);
      end
    end
  end

  eco_bist_misr #(
    .SIG_W(SIG_W),
    .W    (W)
  ) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(load),
    .en (misr_en),
    .d  (y_i),
    .sig(misr_sig)
  );

endmodule

// File: tb/tb_eco_bist_ctrl.sv
// Self-checking bench for eco_bist_ctrl: four instances covering short runs, constant response,
// full-length combinational vs. two-stage registered netlist, and reset/start abuse.
`timescale 1ns/1ps
module tb_eco_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] key;

  logic        start_s, start_t, start_c;
  logic [15:0] golden_s, golden_t, golden_c;
  logic [3:0]  a_s, b_s, y_s, a_t, b_t, y_t, a_c, b_c, y_c, a_l, b_l, y_l;
  logic        busy_s, done_s, pass_s, busy_t, done_t, pass_t;
  logic        busy_c, done_c, pass_c, busy_l, done_l, pass_l;
  logic [15:0] sig_s, sig_t, sig_c, sig_l;
  logic [3:0]  l_r1, l_r2;
`ifdef ECO_BIST_DIAG_EN
  logic        step_mode_s, step_s;
  logic [15:0] dcnt [4];
  logic [15:0] dsig [4];
`endif

  logic [7:0] exp_seq [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  typedef struct {
    logic [3:0]  key;
    logic [15:0] flip;
    logic        exp_pass;
  } vec_t;
  vec_t vt [5];

  // Test netlist: 4-bit add with an output XOR key
  function automatic logic [3:0] netlist(input logic [7:0] ab, input logic [3:0] k);
    return (ab[7:4] + ab[3:0]) ^ k;
  endfunction

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference signature: walk the pattern sequence and fold each response in
  function automatic logic [15:0] model_sig(input int npat, input logic [3:0] k, input bit ones);
    logic [15:0] s;
    logic [7:0]  pat;
    logic [3:0]  y;
    s   = '0;
    pat = 8'h01;
    for (int i = 0; i < npat; i++) begin
      y   = ones ? 4'h1 : netlist(pat, k);
      s   = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {12'h000, y};
      pat = lfsr_adv(pat);
    end
    return s;
  endfunction

  assign y_s = netlist({a_s, b_s}, key);
  assign y_t = 4'h1;
  assign y_c = netlist({a_c, b_c}, key);
  always @(posedge clk) begin
    l_r1 <= netlist({a_l, b_l}, key);
    l_r2 <= l_r1;
  end
  assign y_l = l_r2;

  eco_bist_ctrl #(.W(4), .NPAT(4), .DUT_LAT(0), .SEED(16'h0001), .SIG_W(16)) u_s (
    .clk(clk), .rst(rst), .start(start_s), .golden_i(golden_s), .y_i(y_s),
`ifdef ECO_BIST_DIAG_EN
    .step_mode(step_mode_s), .step(step_s), .diag_cnt(dcnt[0]), .diag_sig(dsig[0]),
`endif
    .a_o(a_s), .b_o(b_s), .busy(busy_s), .done(done_s), .pass(pass_s), .signature(sig_s));

  eco_bist_ctrl #(.W(4), .NPAT(2), .DUT_LAT(0), .SEED(16'h0001), .SIG_W(16)) u_t (
    .clk(clk), .rst(rst), .start(start_t), .golden_i(golden_t), .y_i(y_t),
`ifdef ECO_BIST_DIAG_EN
    .step_mode(1'b0), .step(1'b0), .diag_cnt(dcnt[1]), .diag_sig(dsig[1]),
`endif
    .a_o(a_t), .b_o(b_t), .busy(busy_t), .done(done_t), .pass(pass_t), .signature(sig_t));

  eco_bist_ctrl #(.W(4), .NPAT(256), .DUT_LAT(0), .SEED(16'h0001), .SIG_W(16)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .golden_i(golden_c), .y_i(y_c),
`ifdef ECO_BIST_DIAG_EN
    .step_mode(1'b0), .step(1'b0), .diag_cnt(dcnt[2]), .diag_sig(dsig[2]),
`endif
    .a_o(a_c), .b_o(b_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

  eco_bist_ctrl #(.W(4), .NPAT(256), .DUT_LAT(2), .SEED(16'h0001), .SIG_W(16)) u_l (
    .clk(clk), .rst(rst), .start(start_c), .golden_i(golden_c), .y_i(y_l),
`ifdef ECO_BIST_DIAG_EN
    .step_mode(1'b0), .step(1'b0), .diag_cnt(dcnt[3]), .diag_sig(dsig[3]),
`endif
    .a_o(a_l), .b_o(b_l), .busy(busy_l), .done(done_l), .pass(pass_l), .signature(sig_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_s;
      1:       return done_t;
      2:       return done_c;
      default: return done_l;
    endcase
  endfunction

  task automatic pulse_start(input int sel);
    case (sel)
      0:       start_s = 1'b1;
      1:       start_t = 1'b1;
      default: start_c = 1'b1;
    endcase
    tick();
    start_s = 1'b0;
    start_t = 1'b0;
    start_c = 1'b0;
  endtask

  // Count cycles until the selected done pulse; an expired bound is a failure
  task automatic run_wait(input int sel, input int limit, output int cyc);
    cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (done_of(sel)) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout sel=%0d: no done within %0d cycles", sel, limit);
    end
  endtask

  initial begin
    int cyc, bl, dc, dl, seen;
    logic [15:0] exp;

    vt[0] = '{key: 4'h0, flip: 16'h0000, exp_pass: 1'b1};
    vt[1] = '{key: 4'h5, flip: 16'h0001, exp_pass: 1'b0};
    vt[2] = '{key: 4'hF, flip: 16'h0000, exp_pass: 1'b1};
    vt[3] = '{key: 4'hA, flip: 16'h8000, exp_pass: 1'b0};
    vt[4] = '{key: 4'h9, flip: 16'h0000, exp_pass: 1'b1};

    rst = 1'b1; key = 4'h0;
    start_s = 1'b0; start_t = 1'b0; start_c = 1'b0;
    golden_s = '0; golden_t = '0; golden_c = '0;
`ifdef ECO_BIST_DIAG_EN
    step_mode_s = 1'b0; step_s = 1'b0;
`endif
    tick();
    // start held across an edge while in reset must not launch a run
    start_s = 1'b1;
    tick();
    check("rst_start_busy", 32'(busy_s), 32'h0);
    start_s = 1'b0;
    check("rst_a", 32'(a_s), 32'h0);
    check("rst_b", 32'(b_s), 32'h0);
    check("rst_done", 32'(done_s), 32'h0);
    check("rst_pass", 32'(pass_s), 32'h0);
    check("rst_sig", 32'(sig_s), 32'h0);
`ifdef ECO_BIST_DIAG_EN
    check("rst_diag_cnt", 32'(dcnt[0]), 32'h0);
    check("rst_diag_sig", 32'(dsig[0]), 32'h0);
`endif
    rst = 1'b0;
    tick();

    // Pattern sequence and done timing, start during DONE ignored
    key = 4'h0;
    golden_s = model_sig(4, key, 1'b0);
    pulse_start(0);
    check("seq_busy", 32'(busy_s), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check($sformatf("seq_ab%0d", i), 32'({a_s, b_s}), 32'(exp_seq[i]));
    end
    tick();
    check("seq_ab_done", 32'({a_s, b_s}), 32'h0);
    check("seq_busy_done", 32'(busy_s), 32'h0);
    check("seq_done_early", 32'(done_s), 32'h0);
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    check("seq_done_at5", 32'(done_s), 32'h1);
    check("seq_sig", 32'(sig_s), 32'(golden_s));
    check("seq_pass", 32'(pass_s), 32'h1);
    tick();
    check("seq_done_pulse", 32'(done_s), 32'h0);
    check("seq_start_in_done", 32'(busy_s), 32'h0);

    // Table of keyed runs with good and corrupted golden values
    for (int v = 0; v < 5; v++) begin
      key = vt[v].key;
      golden_s = model_sig(4, vt[v].key, 1'b0) ^ vt[v].flip;
      pulse_start(0);
      run_wait(0, 20, cyc);
      check($sformatf("tbl%0d_cycles", v), 32'(cyc), 32'd5);
      check($sformatf("tbl%0d_sig", v), 32'(sig_s), 32'(model_sig(4, vt[v].key, 1'b0)));
      check($sformatf("tbl%0d_pass", v), 32'(pass_s), 32'(vt[v].exp_pass));
      tick();
    end

    // Constant response compaction
    golden_t = 16'h0003;
    pulse_start(1);
    run_wait(1, 20, cyc);
    check("cmp_cycles", 32'(cyc), 32'd3);
    check("cmp_sig", 32'(sig_t), 32'h0003);
    check("cmp_pass", 32'(pass_t), 32'h1);
    golden_t = 16'h0004;
    pulse_start(1);
    run_wait(1, 20, cyc);
    check("cmp_sig2", 32'(sig_t), 32'h0003);
    check("cmp_pass2", 32'(pass_t), 32'h0);

    // Randomized short runs
    for (int r = 0; r < 8; r++) begin
      bit good;
      key  = 4'($urandom);
      good = 1'($urandom);
      exp  = model_sig(4, key, 1'b0);
      golden_s = good ? exp : (exp ^ 16'(($urandom % 16'hFFFF) + 1));
      repeat ($urandom_range(0, 3)) tick();
      pulse_start(0);
      run_wait(0, 20, cyc);
      check($sformatf("rnd%0d_sig", r), 32'(sig_s), 32'(exp));
      check($sformatf("rnd%0d_pass", r), 32'(pass_s), 32'(good));
    end

    // Combinational vs. two-stage registered netlist on full-length runs
    key = 4'($urandom);
    exp = model_sig(256, key, 1'b0);
    golden_c = exp;
    pulse_start(2);
    bl = 0; dc = 0; dl = 0;
    for (int i = 1; i <= 400 && dl == 0; i++) begin
      if (busy_l) bl++;
      tick();
      if (done_c && dc == 0) dc = i;
      if (done_l) dl = i;
    end
    check("lat_done_c", 32'(dc), 32'd257);
    check("lat_done_l", 32'(dl), 32'd259);
    check("lat_busy_l", 32'(bl), 32'd258);
    check("lat_sig_c", 32'(sig_c), 32'(exp));
    check("lat_sig_l", 32'(sig_l), 32'(exp));
    check("lat_pass_l", 32'(pass_l), 32'h1);
    tick();

    // Spurious start during RUN is ignored
    golden_c = exp ^ 16'h0010;
    pulse_start(2);
    repeat (50) tick();
    pulse_start(2);
    run_wait(3, 400, cyc);
    check("abuse_cycles", 32'(cyc), 32'd208);
    check("abuse_sig_c", 32'(sig_c), 32'(exp));
    check("abuse_sig_l", 32'(sig_l), 32'(exp));
    check("abuse_pass", 32'(pass_l), 32'h0);
    tick();

    // Asynchronous reset mid-run, then a clean restart
    key = key ^ 4'h6;
    exp = model_sig(256, key, 1'b0);
    golden_c = exp;
    pulse_start(2);
    repeat (100) tick();
    #3 rst = 1'b1;
    #1;
    check("midrst_ab", 32'({a_c, b_c}), 32'h0);
    check("midrst_busy", 32'(busy_c), 32'h0);
    check("midrst_sig", 32'(sig_c), 32'h0);
    check("midrst_busy_l", 32'(busy_l), 32'h0);
    start_c = 1'b1;
    tick();
    check("midrst_start_busy", 32'(busy_c), 32'h0);
    rst = 1'b0;
    start_c = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done_c || done_l || busy_c) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'h0);
    pulse_start(2);
    run_wait(3, 400, cyc);
    check("restart_cycles", 32'(cyc), 32'd259);
    check("restart_sig_c", 32'(sig_c), 32'(exp));
    check("restart_sig_l", 32'(sig_l), 32'(exp));
    check("restart_pass", 32'(pass_c), 32'h1);
    tick();

`ifdef ECO_BIST_DIAG_EN
    // Single stepping freezes the stimulus between step pulses
    key = 4'h3;
    golden_s = model_sig(4, key, 1'b0);
    step_mode_s = 1'b1;
    pulse_start(0);
    repeat (3) tick();
    check("diag_ab0", 32'({a_s, b_s}), 32'h01);
    check("diag_cnt0", 32'(dcnt[0]), 32'd0);
    for (int s = 1; s <= 3; s++) begin
      step_s = 1'b1;
      tick();
      step_s = 1'b0;
      check($sformatf("diag_step%0d", s), 32'({a_s, b_s}), 32'(exp_seq[s]));
      repeat (2) tick();
      check($sformatf("diag_hold%0d", s), 32'({a_s, b_s}), 32'(exp_seq[s]));
    end
    check("diag_cnt3", 32'(dcnt[0]), 32'd3);
    step_mode_s = 1'b0;
    run_wait(0, 20, cyc);
    check("diag_sig", 32'(sig_s), 32'(golden_s));
    check("diag_pass", 32'(pass_s), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
